// File: rtl/id_ex_stage_md_pkg.sv
// Shared constants for the ID->EX stage: mult/div latencies, NOP encoding and MD op kinds.
package id_ex_stage_md_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_kind_e;

endpackage

// File: rtl/id_ex_stage_md_md_busy_counter.sv
// Mult/div occupancy counter: loads the op latency on start, counts down to zero,
// and pulses done for one cycle when the count leaves 1.
module md_busy_counter
  import id_ex_stage_md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  md_kind_e kind,
  output logic     busy,
  output logic     done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] start_val;

  assign start_val = (kind == MD_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      // A reload on the same edge supersedes the completion of the previous op.
      done <= (cnt == CNT_W'(1)) && !start;
      if (start)
        cnt <= start_val;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage_md.sv
// ID->EX pipeline register with flush/stall control and an integrated mult/div busy
// tracker that requests a decode stall on HI/LO hazards.
module id_ex_stage_md
  import id_ex_stage_md_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int PC_W     = 32,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc_d,
  input  logic               cmprst_d,
  input  logic               valid_d,
  input  logic               stall,
  input  logic               flush,
  input  logic               md_start_d,
  input  logic               md_div_d,
  input  logic               md_write_d,
  input  logic               hilo_rd_d,
  output logic [INSTR_W-1:0] instr_e,
  output logic [PC_W-1:0]    pc_e,
  output logic               cmprst_e,
  output logic               valid_e,
  output logic               md_busy,
  output logic               md_done,
  output logic               md_stall_d
);

  logic     load;
  logic     md_start;
  md_kind_e md_kind;

  assign load     = !flush && !stall;
  assign md_start = load && valid_d && md_start_d;
  assign md_kind  = md_div_d ? MD_DIV : MD_MULT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_e  <= '0;
      pc_e     <= '0;
      cmprst_e <= 1'b0;
      valid_e  <= 1'b0;
    end else if (flush) begin
      // PC survives the bubble so an exception can still report it.
      instr_e  <= INSTR_W'(NOP_INSTR);
      pc_e     <= pc_d;
      cmprst_e <= 1'b0;
      valid_e  <= 1'b0;
    end else if (!stall) begin
      instr_e  <= instr_d;
      pc_e     <= pc_d;
      cmprst_e <= cmprst_d;
      valid_e  <= valid_d;
    end
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .kind  (md_kind),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign md_stall_d = valid_d && md_busy && (md_start_d || md_write_d || hilo_rd_d);

endmodule

// File: tb/tb_id_ex_stage_md.sv
// Directed-vector bench for id_ex_stage_md: payload load/stall/flush and mult/div tracking.
module tb_id_ex_stage_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        cmprst_d, valid_d, stall, flush;
  logic        md_start_d, md_div_d, md_write_d, hilo_rd_d;
  logic [31:0] instr_e;
  logic [31:0] pc_e;
  logic        cmprst_e, valid_e, md_busy, md_done, md_stall_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_md #(
    .INSTR_W (32), .PC_W (32), .MULT_LAT (5), .DIV_LAT (10), .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .cmprst_d   (cmprst_d),
    .valid_d    (valid_d),
    .stall      (stall),
    .flush      (flush),
    .md_start_d (md_start_d),
    .md_div_d   (md_div_d),
    .md_write_d (md_write_d),
    .hilo_rd_d  (hilo_rd_d),
    .instr_e    (instr_e),
    .pc_e       (pc_e),
    .cmprst_e   (cmprst_e),
    .valid_e    (valid_e),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_stall_d (md_stall_d)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_d = '0; pc_d = '0; cmprst_d = 0; valid_d = 0; stall = 0; flush = 0;
    md_start_d = 0; md_div_d = 0; md_write_d = 0; hilo_rd_d = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #3;
    chk("rst_instr_e", instr_e, 32'h0);
    chk("rst_pc_e", pc_e, 32'h0);
    chk("rst_valid_e", {31'b0, valid_e}, 32'h0);
    chk("rst_busy", {31'b0, md_busy}, 32'h0);
    chk("rst_done", {31'b0, md_done}, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Plain load, then hold under stall
    instr_d = 32'h0109_4021; pc_d = 32'h0000_0100; cmprst_d = 1; valid_d = 1;
    tick();
    chk("load_instr_e", instr_e, 32'h0109_4021);
    chk("load_valid_e", {31'b0, valid_e}, 32'h1);
    chk("load_pc_e", pc_e, 32'h0000_0100);
    chk("load_cmprst_e", {31'b0, cmprst_e}, 32'h1);
    stall = 1; instr_d = 32'hFFFF_FFFF; pc_d = 32'h0000_0200; cmprst_d = 0; valid_d = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr_e", instr_e, 32'h0109_4021);
      chk("stall_pc_e", pc_e, 32'h0000_0100);
      chk("stall_valid_e", {31'b0, valid_e}, 32'h1);
    end

    // Flush beats stall; PC still captured
    flush = 1; stall = 1; instr_d = 32'h0000_1234; pc_d = 32'h0000_0300; cmprst_d = 1; valid_d = 1;
    tick();
    chk("flush_instr_e", instr_e, 32'h0);
    chk("flush_valid_e", {31'b0, valid_e}, 32'h0);
    chk("flush_pc_e", pc_e, 32'h0000_0300);
    chk("flush_cmprst_e", {31'b0, cmprst_e}, 32'h0);
    idle_inputs();

    // Mult: busy 5 cycles, done on the 5th edge; mflo stalls decode while busy
    valid_d = 1; md_start_d = 1; md_div_d = 0; instr_d = 32'h0109_0018;
    tick();
    chk("mult_busy0", {31'b0, md_busy}, 32'h1);
    chk("mult_done0", {31'b0, md_done}, 32'h0);
    md_start_d = 0; instr_d = 32'h0000_0000; valid_d = 0;
    tick();
    valid_d = 1; hilo_rd_d = 1; stall = 1; instr_d = 32'h0000_4012;
    #1;
    chk("mflo_stall_req", {31'b0, md_stall_d}, 32'h1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("mult_busy", {31'b0, md_busy}, {31'b0, (k < 5)});
      chk("mult_done", {31'b0, md_done}, {31'b0, (k == 5)});
      chk("mult_stall_d", {31'b0, md_stall_d}, {31'b0, (k < 5)});
    end
    idle_inputs();

    // Collision: stalled div start while counter==1 waits one bubble
    valid_d = 1; md_start_d = 1; md_div_d = 0;
    tick();
    md_start_d = 0; valid_d = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("col_busy_at1", {31'b0, md_busy}, 32'h1);
    valid_d = 1; md_start_d = 1; md_div_d = 1; stall = 1;
    #1;
    chk("col_stall_req", {31'b0, md_stall_d}, 32'h1);
    tick();
    chk("col_busy_gap", {31'b0, md_busy}, 32'h0);
    chk("col_done_gap", {31'b0, md_done}, 32'h1);
    chk("col_stall_rel", {31'b0, md_stall_d}, 32'h0);
    stall = 0;
    tick();
    chk("col_div_busy", {31'b0, md_busy}, 32'h1);
    chk("col_div_done", {31'b0, md_done}, 32'h0);
    idle_inputs();
    for (int k = 1; k <= 10; k++) tick();
    chk("col_div_done10", {31'b0, md_done}, 32'h1);
    chk("col_div_idle10", {31'b0, md_busy}, 32'h0);
    tick();

    // Div followed by a flush 2 cycles later: count is unaffected
    valid_d = 1; md_start_d = 1; md_div_d = 1;
    tick();
    idle_inputs();
    tick();
    flush = 1;
    tick();
    flush = 0;
    for (int k = 3; k <= 10; k++) begin
      tick();
      chk("div_busy", {31'b0, md_busy}, {31'b0, (k < 10)});
      chk("div_done", {31'b0, md_done}, {31'b0, (k == 10)});
    end
    tick();
    chk("div_done_clr", {31'b0, md_done}, 32'h0);

    // Flushed start never begins an op
    valid_d = 1; md_start_d = 1; md_div_d = 0; flush = 1;
    tick();
    chk("fl_start_busy", {31'b0, md_busy}, 32'h0);
    idle_inputs();
    tick();
    chk("fl_start_busy2", {31'b0, md_busy}, 32'h0);
    chk("fl_start_done", {31'b0, md_done}, 32'h0);

    // Async reset mid-div with counter at 7
    valid_d = 1; md_start_d = 1; md_div_d = 1; instr_d = 32'h0109_001A; pc_d = 32'h40; cmprst_d = 1;
    tick();
    idle_inputs();
    valid_d = 1; instr_d = 32'h0109_4021; cmprst_d = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_busy", {31'b0, md_busy}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_instr_e", instr_e, 32'h0);
    chk("arst_pc_e", pc_e, 32'h0);
    chk("arst_valid_e", {31'b0, valid_e}, 32'h0);
    chk("arst_cmprst_e", {31'b0, cmprst_e}, 32'h0);
    chk("arst_busy", {31'b0, md_busy}, 32'h0);
    chk("arst_done", {31'b0, md_done}, 32'h0);
    idle_inputs();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_done", {31'b0, md_done}, 32'h0);
    end
    chk("post_rst_busy", {31'b0, md_busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
